// File: rtl/hazard_ctrl_pkg.sv
// Shared types and the source/slot match helper for the hazard controller.
// Imported by hazard_ctrl.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        HZ_RUN        = 2'd0,
        HZ_LOAD_STALL = 2'd1,
        HZ_FLUSH      = 2'd2,
        HZ_FREEZE     = 2'd3
    } hz_mode_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       rf_en;
        logic       is_load;
    } hz_slot_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs1;
        logic       use_rs2;
        logic [4:0] rd;
        logic       rf_en;
        logic       is_load;
        logic       redirect;
        logic       dm_busy;
    } hazard_in_t;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_all;
        logic flush_id;
        logic flush_ex;
        logic byp_a;
        logic byp_b;
    } hazard_out_t;

    localparam hz_slot_t SLOT_BUBBLE = '0;

    // True when an in-flight writer produces the value this source reads.
    // x0 is never a real producer.
    function automatic logic slot_match_f(
        input hz_slot_t   s,
        input logic [4:0] src,
        input logic       use_src
    );
        return s.valid && s.rf_en && use_src &&
               (s.rd == src) && (s.rd != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Hazard controller: shadows EX/MEM/WB destinations and drives
// stall, flush, forwarding, ID bypass and event counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 id_valid,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [4:0]           id_rd,
    input  logic                 id_rf_en,
    input  logic                 id_is_load,
    input  logic                 ex_redirect,
    input  logic                 dm_busy,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 stall_all,
    output logic                 flush_id,
    output logic                 flush_ex,
    output logic [1:0]           fwd_a_sel,
    output logic [1:0]           fwd_b_sel,
    output logic                 id_byp_a,
    output logic                 id_byp_b,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    hazard_in_t  hin;
    hazard_out_t hout;

    hz_slot_t ex_q;
    hz_slot_t mem_q;
    hz_slot_t wb_q;
    hz_slot_t id_slot;

    fwd_sel_e fwd_a_q;
    fwd_sel_e fwd_b_q;
    fwd_sel_e fwd_a_d;
    fwd_sel_e fwd_b_d;

    hz_mode_e mode;
    hz_mode_e mode_q;

    logic m_ex_a;
    logic m_ex_b;
    logic m_mem_a;
    logic m_mem_b;
    logic m_wb_a;
    logic m_wb_b;
    logic load_use;

    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_q;

    // Gather the ID decode fields and pipeline events into one bundle.
    always_comb begin
        hin          = '0;
        hin.valid    = id_valid;
        hin.rs1      = id_rs1;
        hin.rs2      = id_rs2;
        hin.use_rs1  = id_use_rs1;
        hin.use_rs2  = id_use_rs2;
        hin.rd       = id_rd;
        hin.rf_en    = id_rf_en;
        hin.is_load  = id_is_load;
        hin.redirect = ex_redirect;
        hin.dm_busy  = dm_busy;
    end

    assign m_ex_a  = slot_match_f(ex_q,  hin.rs1, hin.use_rs1);
    assign m_ex_b  = slot_match_f(ex_q,  hin.rs2, hin.use_rs2);
    assign m_mem_a = slot_match_f(mem_q, hin.rs1, hin.use_rs1);
    assign m_mem_b = slot_match_f(mem_q, hin.rs2, hin.use_rs2);
    assign m_wb_a  = slot_match_f(wb_q,  hin.rs1, hin.use_rs1);
    assign m_wb_b  = slot_match_f(wb_q,  hin.rs2, hin.use_rs2);

    assign load_use = hin.valid && ex_q.is_load && (m_ex_a || m_ex_b);

    assign id_slot = '{
        valid:   hin.valid,
        rd:      hin.rd,
        rf_en:   hin.rf_en,
        is_load: hin.is_load
    };

    // Pick this cycle's mode; memory freeze dominates a pending redirect.
    always_comb begin
        mode = HZ_RUN;
        if (hin.dm_busy) begin
            mode = HZ_FREEZE;
        end else if (hin.redirect) begin
            mode = HZ_FLUSH;
        end else if (load_use) begin
            mode = HZ_LOAD_STALL;
        end
    end

    // Forwarding for the instruction about to enter EX; youngest wins.
    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (m_ex_a && !ex_q.is_load) begin
            fwd_a_d = FWD_MEM;
        end else if (m_mem_a) begin
            fwd_a_d = FWD_WB;
        end
        if (m_ex_b && !ex_q.is_load) begin
            fwd_b_d = FWD_MEM;
        end else if (m_mem_b) begin
            fwd_b_d = FWD_WB;
        end
    end

    // Pipeline control decode from the selected mode.
    always_comb begin
        hout = '0;
        unique case (mode)
            HZ_FREEZE: begin
                hout.stall_if  = 1'b1;
                hout.stall_id  = 1'b1;
                hout.stall_all = 1'b1;
            end
            HZ_FLUSH: begin
                hout.flush_id = 1'b1;
                hout.flush_ex = 1'b1;
            end
            HZ_LOAD_STALL: begin
                hout.stall_if = 1'b1;
                hout.stall_id = 1'b1;
                hout.flush_ex = 1'b1;
            end
            default: ;
        endcase
        hout.byp_a = m_wb_a;
        hout.byp_b = m_wb_b;
    end

    // Advance the shadow slots and capture forwarding selects.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ex_q    <= SLOT_BUBBLE;
            mem_q   <= SLOT_BUBBLE;
            wb_q    <= SLOT_BUBBLE;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
            mode_q  <= HZ_RUN;
        end else begin
            mode_q <= mode;
            if (mode != HZ_FREEZE) begin
                mem_q <= ex_q;
                wb_q  <= mem_q;
                if (mode == HZ_RUN) begin
                    ex_q    <= id_slot;
                    fwd_a_q <= fwd_a_d;
                    fwd_b_q <= fwd_b_d;
                end else begin
                    ex_q    <= SLOT_BUBBLE;
                    fwd_a_q <= FWD_RF;
                    fwd_b_q <= FWD_RF;
                end
            end
        end
    end

    // Count stall and flush cycles; both wrap naturally.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (mode == HZ_FREEZE || mode == HZ_LOAD_STALL) begin
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            end
            if (mode == HZ_FLUSH) begin
                flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // A load stalls its consumer once; afterwards EX holds a bubble.
    a_single_load_stall: assert property (
        @(posedge clk) disable iff (!arst_n)
        (mode_q == HZ_LOAD_STALL) |-> (mode != HZ_LOAD_STALL)
    );

    assign stall_if  = hout.stall_if;
    assign stall_id  = hout.stall_id;
    assign stall_all = hout.stall_all;
    assign flush_id  = hout.flush_id;
    assign flush_ex  = hout.flush_ex;
    assign id_byp_a  = hout.byp_a;
    assign id_byp_b  = hout.byp_b;
    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core (IF, ID, EX, MEM, WB). It shadows the destination-register state of the instructions in EX, MEM and WB. From that state it drives the stall and flush controls for the pipeline registers, the operand forwarding selects used in EX, and the ID-stage write-back bypass. It also keeps stall and flush event counters for performance analysis. It sits beside the ID stage and takes its decode fields directly.

## Interface
- `CNT_WIDTH`, 32, width of the performance counters
- `clk`  in  1  core clock
- `arst_n`  in  1  reset; asynchronous, active-low
- `id_valid`  in  1  ID holds a real instruction
- `id_rs1`, `id_rs2`  in  5 each  ID source registers
- `id_use_rs1`, `id_use_rs2`  in  1 each  ID instruction reads that source
- `id_rd`  in  5  ID destination register
- `id_rf_en`  in  1  ID instruction writes the RF
- `id_is_load`  in  1  ID instruction is a load (`wb_sel` = memory)
- `ex_redirect`  in  1  EX resolved a taken branch or jump
- `dm_busy`  in  1  data memory not ready; MEM cannot complete
- `stall_if`  out  1  hold the PC and the IF/ID register
- `stall_id`  out  1  hold the ID/EX register input (ID re-presents)
- `stall_all`  out  1  freeze EX/MEM and MEM/WB
- `flush_id`  out  1  clear the IF/ID register to a bubble
- `flush_ex`  out  1  clear the ID/EX register to a bubble
- `fwd_a_sel`, `fwd_b_sel`  out  2 each  EX operand source: 0 = RF/ID value, 1 = MEM ALU result, 2 = WB data, 3 = unused
- `id_byp_a`, `id_byp_b`  out  1 each  ID takes `wb_data` instead of the RF read
- `stall_cnt`, `flush_cnt`  out  `CNT_WIDTH` each  event counters

## Operation
- Three shadow slots: `ex_q`, `mem_q`, `wb_q`. Each holds {valid, rd, rf_en, is_load}.
- An ID source matches a slot when all of these hold: the slot is valid, `rf_en` = 1, slot `rd` = the ID source, the `use` bit = 1, and `rd` ≠ 0.
- Load-use condition: `id_valid`, `ex_q.is_load`, and either ID source matches `ex_q`.
- Priority each cycle (highest first):
  1. **FREEZE** (`dm_busy`): `stall_if = stall_id = stall_all = 1`. All slots and the forwarding selects hold.
  2. **FLUSH** (`ex_redirect`): `flush_id = flush_ex = 1`. Shift `ex_q` into `mem_q` and `mem_q` into `wb_q`; `ex_q` becomes a bubble.
  3. **LOAD_STALL**: `stall_if = stall_id = 1`, `flush_ex = 1`. Shift as in FLUSH with `ex_q` becoming a bubble.
  4. **RUN**: shift, and `ex_q` takes {`id_valid`, `id_rd`, `id_rf_en`, `id_is_load`}.
- A redirect held during FREEZE is acted on in the first cycle with `dm_busy` = 0. EX holds `ex_redirect` asserted until then.
- Registered forwarding: when the ID instruction enters EX (RUN only), capture per source: 1 if it matches `ex_q` and `ex_q` is not a load; else 2 if it matches `mem_q`; else 0. The most recent producer wins. In FLUSH and LOAD_STALL the selects are loaded with 0.
- `id_byp_a/b`: combinational; the ID source matches `wb_q`. Covers RF write and read in the same cycle.
- `stall_cnt`: +1 in every FREEZE or LOAD_STALL cycle. `flush_cnt`: +1 in every FLUSH cycle. Both wrap modulo 2^`CNT_WIDTH`.
- The controller state is the registered mode (RUN, LOAD_STALL, FLUSH, FREEZE), recomputed every cycle from the priority list above. At most one LOAD_STALL cycle occurs per load; on the following cycle the load is in MEM and forwarding is used.

## Timing
- Reset (asynchronous, `arst_n` low):
  - all slots invalid; mode = RUN
  - `fwd_*_sel` = 0; counters = 0
  - stall/flush/bypass outputs = 0, since no slot is valid and no input is active
- Reset asserted mid-stall or mid-flush returns to RUN immediately. The first cycle after release is RUN.
- Stall, flush and bypass outputs are combinational from the inputs and slots, valid in the same cycle.
- `fwd_*_sel` is registered: the value is valid in the cycle the instruction occupies EX.
- Counters update on the clock edge ending the counted cycle.

## Structure
- Put the following in the shared `hazard_ctrl_pkg`:
  - the `fwd_sel_e` enum (`FWD_RF`, `FWD_MEM`, `FWD_WB`)
  - the `hz_mode_e` enum
  - the `hz_slot_t` struct
  - the `hazard_in_t` and `hazard_out_t` structs
- The match logic is written once as the package function `slot_match_f`, called six times.
- No sub-module is needed.

## Test plan
- **Back-to-back ALU dependency:** `add x5` in ID, then a dependent `sub` reading x5 as rs1 → next cycle `fwd_a_sel` = 1, no stall.
- **Load-use:** `lw x6` followed by `add` with rs2 = x6 → one cycle with `stall_if = stall_id = flush_ex = 1`, then `fwd_b_sel` = 2, and `stall_cnt` = 1.
- **Write to x0:** writer with rd = x0 followed by a reader of x0 → `fwd` = 0, no stall, `id_byp` = 0.
- **Redirect during load-use:** `ex_redirect` and the load-use condition in the same cycle → FLUSH wins, `flush_id = flush_ex = 1`, `stall_if` = 0, `flush_cnt` += 1.
- **Freeze over redirect:** `dm_busy` for 3 cycles with `ex_redirect` held → 3 FREEZE cycles with slots unchanged, then one FLUSH; `stall_cnt` = 3, `flush_cnt` = 1.
- **Reset mid-LOAD_STALL, and counter wrap:** assert reset during LOAD_STALL → all outputs 0 next cycle. Separately, with `CNT_WIDTH` = 4, 16 stalls → `stall_cnt` wraps to 0.
